// File: rtl/sigdel_decim_if.sv
// Bitstream-in / PCM-out bundle for the sigma-delta CIC decimator.
// master: bitstream source and PCM consumer; slave: the decimator.
interface sigdel_decim_if #(
  parameter int OUT_W = 8
);
  logic             bit_in;
  logic             bit_en;
  logic [OUT_W-1:0] sample_out;
  logic             sample_valid;
  logic             warm;

  modport master (
    output bit_in,
    output bit_en,
    input  sample_out,
    input  sample_valid,
    input  warm
  );

  modport slave (
    input  bit_in,
    input  bit_en,
    output sample_out,
    output sample_valid,
    output warm
  );
endinterface

// File: rtl/sigdel_decim.sv
// CIC (sinc^N) decimator turning the 1-bit modulator stream into OUT_W-bit PCM, OSR = 2**LOG2_OSR.
// Build option: define SIGDEL_DEC_SINC3_EN for a third-order filter (default is second order).
module sigdel_decim #(
  parameter int LOG2_OSR = 6,
  parameter int OUT_W    = 8
) (
  input logic           clk,
  input logic           rst,
  sigdel_decim_if.slave bus
);

`ifdef SIGDEL_DEC_SINC3_EN
  localparam int N = 3;
`else
  localparam int N = 2;
`endif
  localparam int W     = N * LOG2_OSR + 1;
  localparam int SHIFT = N * LOG2_OSR - OUT_W;

  localparam logic [LOG2_OSR-1:0] PHASE_LAST  = {LOG2_OSR{1'b1}};
  localparam logic [LOG2_OSR-1:0] PHASE_ONE   = {{(LOG2_OSR-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]        SAT_MAX     = {{(W-OUT_W){1'b0}}, {OUT_W{1'b1}}};
  localparam logic [1:0]          WARM_EVENTS = 2'(N);

  logic [LOG2_OSR-1:0] phase_r;
  logic                event_r;
  logic [W-1:0]        integ_r    [N];
  logic [W-1:0]        comb_dly_r [N];
  logic [1:0]          warm_cnt_r;
  logic [W-1:0]        comb_tap_s [N];
  logic [W-1:0]        y_s;
  logic [W-1:0]        shifted_s;
  logic [OUT_W-1:0]    sat_s;

  // Integrator cascade and phase counter; event_r marks that integ_r now holds the post-event value.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_r <= {LOG2_OSR{1'b0}};
      event_r <= 1'b0;
      for (int k = 0; k < N; k++) begin
        integ_r[k] <= {W{1'b0}};
      end
    end else begin
      event_r <= bus.bit_en && (phase_r == PHASE_LAST);
      if (bus.bit_en) begin
        phase_r    <= phase_r + PHASE_ONE;
        integ_r[0] <= integ_r[0] + {{(W-1){1'b0}}, bus.bit_in};
        for (int k = 1; k < N; k++) begin
          integ_r[k] <= integ_r[k] + integ_r[k-1];
        end
      end else begin
        phase_r <= phase_r;
      end
    end
  end

  // Comb chain on the last integrator, then scale and clamp so full scale never wraps to zero.
  always_comb begin : comb_chain
    logic [W-1:0] acc;
    acc = integ_r[N-1];
    for (int k = 0; k < N; k++) begin
      comb_tap_s[k] = acc;
      acc           = acc - comb_dly_r[k];
    end
    y_s       = acc;
    shifted_s = y_s >> SHIFT;
    if (shifted_s > SAT_MAX) begin
      sat_s = {OUT_W{1'b1}};
    end else begin
      sat_s = shifted_s[OUT_W-1:0];
    end
  end

  // Comb delays advance only on events; the first N events just prime them.
  always_ff @(posedge clk) begin
    if (rst) begin
      warm_cnt_r       <= 2'd0;
      bus.sample_out   <= {OUT_W{1'b0}};
      bus.sample_valid <= 1'b0;
      bus.warm         <= 1'b0;
      for (int k = 0; k < N; k++) begin
        comb_dly_r[k] <= {W{1'b0}};
      end
    end else begin
      bus.sample_valid <= 1'b0;
      if (event_r) begin
        for (int k = 0; k < N; k++) begin
          comb_dly_r[k] <= comb_tap_s[k];
        end
        if (warm_cnt_r == WARM_EVENTS) begin
          bus.sample_out   <= sat_s;
          bus.sample_valid <= 1'b1;
          bus.warm         <= 1'b1;
        end else begin
          warm_cnt_r <= warm_cnt_r + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sigdel_decim.sv
// Directed, table-driven bench for sigdel_decim: steady patterns, input gaps, reset mid-period.
module tb_sigdel_decim;
  localparam int LOG2_OSR = 6;
  localparam int OUT_W    = 8;
  localparam int OSR      = 1 << LOG2_OSR;
`ifdef SIGDEL_DEC_SINC3_EN
  localparam int N = 3;
`else
  localparam int N = 2;
`endif

  logic clk;
  logic rst;
  int   cmp_cnt;
  int   err_cnt;

  sigdel_decim_if #(.OUT_W(OUT_W)) bus ();

  sigdel_decim #(
    .LOG2_OSR (LOG2_OSR),
    .OUT_W    (OUT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] mask;     // bit value for accepted bit j is mask[j % 4]
    int         div;      // bit_en high one cycle in div
    int         exp_val;  // expected sample_out on every strobe
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input int tag, input int act, input int exp);
    cmp_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s[%0d] @%0t: got %0d, expected %0d", nm, tag, $time, act, exp);
    end
  endtask

  task automatic do_reset(input int tag);
    rst         = 1'b1;
    bus.bit_en  = 1'b0;
    bus.bit_in  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_sample", tag, int'(bus.sample_out), 0);
    chk("rst_valid", tag, int'(bus.sample_valid), 0);
    chk("rst_warm", tag, int'(bus.warm), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Cycle 0 is the current cycle; expected strobe timing is derived from event bit positions.
  task automatic run_stream(input int tag, input logic [3:0] mask, input int div,
                            input int ncyc, input int exp_val);
    int acc;
    int first;
    int exp_v;
    acc   = 0;
    first = div * ((N + 1) * OSR - 1) + 2;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      bus.bit_en = ((cyc % div) == 0);
      bus.bit_in = bus.bit_en ? mask[acc % 4] : 1'b0;
      if (bus.bit_en) acc++;
      @(negedge clk);
      exp_v = (cyc >= first && ((cyc - first) % (div * OSR)) == 0) ? 1 : 0;
      chk("valid", tag, int'(bus.sample_valid), exp_v);
      chk("sample", tag, int'(bus.sample_out), (cyc >= first) ? exp_val : 0);
      chk("warm", tag, int'(bus.warm), (cyc >= first) ? 1 : 0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int first;
    cmp_cnt    = 0;
    err_cnt    = 0;
    rst        = 1'b1;
    bus.bit_en = 1'b0;
    bus.bit_in = 1'b0;

    vecs[0] = '{mask: 4'b1111, div: 1, exp_val: 255};  // full scale saturates
    vecs[1] = '{mask: 4'b0000, div: 1, exp_val: 0};
    vecs[2] = '{mask: 4'b0101, div: 1, exp_val: 128};  // half scale
    vecs[3] = '{mask: 4'b1111, div: 3, exp_val: 255};  // gaps, strobe every 192
    vecs[4] = '{mask: 4'b0111, div: 1, exp_val: 192};  // 3/4 density
    vecs[5] = '{mask: 4'b0001, div: 1, exp_val: 64};   // 1/4 density
    vecs[6] = '{mask: 4'b0101, div: 2, exp_val: 128};

    for (int v = 0; v < 7; v++) begin
      do_reset(v);
      first = vecs[v].div * ((N + 1) * OSR - 1) + 2;
      run_stream(v, vecs[v].mask, vecs[v].div, first + 3 * vecs[v].div * OSR + 2,
                 vecs[v].exp_val);
    end

    // Reset at phase 30 with bit_en high: the bit is dropped and warm-up restarts.
    do_reset(10);
    run_stream(10, 4'b1111, 1, 4 * OSR + 30, 255);
    rst        = 1'b1;
    bus.bit_en = 1'b1;
    bus.bit_in = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    first = (N + 1) * OSR - 1 + 2;
    run_stream(11, 4'b1111, 1, first + OSR + 2, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
